// File: rtl/meter_time_ctrl_if.sv
// Parking meter sequencer bus: meter inputs and status/violation outputs.
// master drives the meter inputs, slave is the sequencer.
interface meter_time_ctrl_if #(
    parameter int W = 14
);
    logic         tick_1hz;
    logic         parked;
    logic         coin_a;
    logic         coin_b;
    logic         clr_time;
    logic [W-1:0] time_left;
    logic [1:0]   state;
    logic         low_time;
    logic         blink;
    logic         viol_en;
    logic         viol_clr;

    modport master (
        output tick_1hz, parked, coin_a, coin_b, clr_time,
        input  time_left, state, low_time, blink, viol_en, viol_clr
    );

    modport slave (
        input  tick_1hz, parked, coin_a, coin_b, clr_time,
        output time_left, state, low_time, blink, viol_en, viol_clr
    );
endinterface

// File: rtl/meter_time_ctrl.sv
// Parking meter time sequencer: balance, countdown, state, violation control.
// Define COIN_EDGE_EN to treat coin inputs as levels credited once per press.
module meter_time_ctrl #(
    parameter int W          = 14,
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 180,
    parameter int COIN_A     = 60,
    parameter int COIN_B     = 120
) (
    input logic              clk,
    input logic              rst,
    meter_time_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAID    = 2'd1,
        LOW     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int WX = W + 2;
    localparam logic [WX-1:0] MAX_X    = WX'(MAX_TIME);
    localparam logic [WX-1:0] COIN_A_X = WX'(COIN_A);
    localparam logic [WX-1:0] COIN_B_X = WX'(COIN_B);
    localparam logic [W-1:0]  THRESH_W = W'(LOW_THRESH);

    logic coin_a_eff;
    logic coin_b_eff;

`ifdef COIN_EDGE_EN
    logic coin_a_prev_q, coin_b_prev_q;
    logic coin_a_pulse_q, coin_b_pulse_q;
    logic coin_a_pulse_d, coin_b_pulse_d;

    // Rising edge of each coin button level
    always_comb begin
        coin_a_pulse_d = bus.coin_a & ~coin_a_prev_q;
        coin_b_pulse_d = bus.coin_b & ~coin_b_prev_q;
    end

    // Register edge pulses so each press credits once, one clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_a_prev_q  <= 1'b0;
            coin_b_prev_q  <= 1'b0;
            coin_a_pulse_q <= 1'b0;
            coin_b_pulse_q <= 1'b0;
        end else begin
            coin_a_prev_q  <= bus.coin_a;
            coin_b_prev_q  <= bus.coin_b;
            coin_a_pulse_q <= coin_a_pulse_d;
            coin_b_pulse_q <= coin_b_pulse_d;
        end
    end

    assign coin_a_eff = coin_a_pulse_q;
    assign coin_b_eff = coin_b_pulse_q;
`else
    assign coin_a_eff = bus.coin_a;
    assign coin_b_eff = bus.coin_b;
`endif

    logic [W-1:0]  time_left_q, time_left_d;
    state_t        state_q, state_d;
    logic          blink_q, blink_d;
    logic          viol_en_q, viol_en_d;
    logic          viol_clr_q, viol_clr_d;
    logic          low_time_q, low_time_d;
    logic          parked_q, parked_d;
    logic          dec;
    logic          coin_hit;
    logic [WX-1:0] add_x;
    logic [WX-1:0] sum_x;

    // Next balance: decrement on tick, add credit, clamp; clear wins
    always_comb begin
        dec      = bus.tick_1hz && (time_left_q != '0);
        coin_hit = coin_a_eff | coin_b_eff;
        add_x    = (coin_a_eff ? COIN_A_X : '0)
                 + (coin_b_eff ? COIN_B_X : '0);
        sum_x    = WX'(time_left_q) - WX'(dec) + add_x;
        if (bus.clr_time) begin
            time_left_d = '0;
        end else if (sum_x > MAX_X) begin
            time_left_d = MAX_X[W-1:0];
        end else begin
            time_left_d = sum_x[W-1:0];
        end
        parked_d = bus.parked;
    end

    // Classify next balance and derive blink and violation controls
    always_comb begin
        state_d    = PAID;
        blink_d    = 1'b0;
        if (time_left_d == '0) begin
            state_d = bus.parked ? EXPIRED : IDLE;
        end else if (time_left_d < THRESH_W) begin
            state_d = LOW;
        end
        case (state_d)
            LOW: begin
                if (state_q == LOW) blink_d = blink_q ^ bus.tick_1hz;
                else                blink_d = 1'b0;
            end
            EXPIRED: blink_d = 1'b1;
            default: blink_d = 1'b0;
        endcase
        viol_en_d  = (state_d == EXPIRED);
        low_time_d = (state_d == LOW);
        viol_clr_d = (parked_q & ~bus.parked)
                   | ((state_q == EXPIRED) && (state_d != EXPIRED)
                      && coin_hit && !bus.clr_time);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Balance and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            time_left_q <= '0;
            blink_q     <= 1'b0;
            viol_en_q   <= 1'b0;
            viol_clr_q  <= 1'b1;
            low_time_q  <= 1'b0;
            parked_q    <= 1'b0;
        end else begin
            time_left_q <= time_left_d;
            blink_q     <= blink_d;
            viol_en_q   <= viol_en_d;
            viol_clr_q  <= viol_clr_d;
            low_time_q  <= low_time_d;
            parked_q    <= parked_d;
        end
    end

    assign bus.time_left = time_left_q;
    assign bus.state     = state_q;
    assign bus.low_time  = low_time_q;
    assign bus.blink     = blink_q;
    assign bus.viol_en   = viol_en_q;
    assign bus.viol_clr  = viol_clr_q;
endmodule

// File: tb/tb_meter_time_ctrl.sv
// Testbench for meter_time_ctrl: directed plan plus randomized traffic
// against a behavioural model, checked through a scoreboard queue.
module tb_meter_time_ctrl;
    logic clk;
    logic rst;

    meter_time_ctrl_if #(.W(14)) bus ();

    meter_time_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [13:0] time_left;
        logic [1:0]  state;
        logic        low_time;
        logic        blink;
        logic        viol_en;
        logic        viol_clr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   pk = 0;

    // model state
    int m_bal = 0, m_st = 0, m_blink = 0, m_ven = 0, m_vclr = 1;
    int m_pprev = 0, m_lastA = 0, m_lastB = 0, m_pendA = 0, m_pendB = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model(input bit r, t, p, a, b, c);
        int ea, eb, nb, nst;
        if (r) begin
            m_bal = 0; m_st = 0; m_blink = 0; m_ven = 0; m_vclr = 1;
            m_pprev = 0; m_lastA = 0; m_lastB = 0;
            m_pendA = 0; m_pendB = 0;
            return;
        end
`ifdef COIN_EDGE_EN
        ea = m_pendA;
        eb = m_pendB;
        m_pendA = (a && !m_lastA) ? 1 : 0;
        m_pendB = (b && !m_lastB) ? 1 : 0;
        m_lastA = a;
        m_lastB = b;
`else
        ea = a;
        eb = b;
`endif
        if (c) nb = 0;
        else begin
            nb = m_bal - ((t && m_bal > 0) ? 1 : 0) + 60 * ea + 120 * eb;
            if (nb > 9999) nb = 9999;
        end
        if (nb == 0)       nst = p ? 3 : 0;
        else if (nb < 180) nst = 2;
        else               nst = 1;
        if (nst == 2)      m_blink = (m_st == 2) ? (t ? 1 - m_blink : m_blink) : 0;
        else if (nst == 3) m_blink = 1;
        else               m_blink = 0;
        m_vclr = ((m_pprev == 1 && !p) ||
                  (m_st == 3 && nst != 3 && !c && (ea + eb) > 0)) ? 1 : 0;
        m_ven  = (nst == 3) ? 1 : 0;
        m_pprev = p;
        m_bal = nb;
        m_st = nst;
    endfunction

    task automatic cyc(input bit r, t, a, b, c);
        exp_t e;
        rst          = r;
        bus.tick_1hz = t;
        bus.coin_a   = a;
        bus.coin_b   = b;
        bus.clr_time = c;
        bus.parked   = pk;
        @(posedge clk);
        model(r, t, pk, a, b, c);
        e.time_left = 14'(m_bal);
        e.state     = 2'(m_st);
        e.low_time  = (m_st == 2);
        e.blink     = m_blink[0];
        e.viol_en   = m_ven[0];
        e.viol_clr  = m_vclr[0];
        sb.push_back(e);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("time_left", int'(bus.time_left), int'(e.time_left));
                chk("state", int'(bus.state), int'(e.state));
                chk("low_time", int'(bus.low_time), int'(e.low_time));
                chk("blink", int'(bus.blink), int'(e.blink));
                chk("viol_en", int'(bus.viol_en), int'(e.viol_en));
                chk("viol_clr", int'(bus.viol_clr), int'(e.viol_clr));
            end
        end
    end

    initial begin
        int kind;
        bit t, a, b, c, r;
        rst = 1'b1;
        bus.tick_1hz = 0; bus.coin_a = 0; bus.coin_b = 0;
        bus.clr_time = 0; bus.parked = 0;

        // 1: reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        // 2: coin_b then 5 ticks into LOW with blink
        cyc(0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0);
            idle(1);
        end

        // 3: saturation at 9999
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 84; i++) begin
            cyc(0, 0, 0, 1, 0);
            idle(1);
        end
        idle(1);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 1, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0);
        idle(2);

        // 4: expire while parked, then depart
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 0);
        pk = 1;
        idle(2);
        cyc(0, 1, 0, 0, 0);
        idle(3);
        pk = 0;
        idle(3);

        // 5: tick and coin_a together at balance 1
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 0);
        pk = 1;
        idle(1);
`ifdef COIN_EDGE_EN
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
`else
        cyc(0, 1, 1, 0, 0);
`endif
        idle(3);

        // 6: clr_time beats coin while EXPIRED; held coin_a level
        cyc(0, 0, 0, 0, 1);
        idle(2);
`ifdef COIN_EDGE_EN
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
`else
        cyc(0, 0, 0, 1, 1);
`endif
        idle(2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
        idle(3);

        // reset mid-countdown in LOW
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(3);
        pk = 0;

        // randomized segments
        for (int seg = 0; seg < 15; seg++) begin
            kind = seg % 3;
            for (int i = 0; i < 200; i++) begin
                r = 0; c = 0; a = 0; b = 0; t = 1;
                if (kind == 0) begin
                    t = ($urandom_range(0, 3) == 0);
                    a = ($urandom_range(0, 15) == 0);
                    b = ($urandom_range(0, 15) == 0);
                    c = ($urandom_range(0, 63) == 0);
                    r = ($urandom_range(0, 499) == 0);
                    if ($urandom_range(0, 31) == 0) pk = ~pk;
                end else if (kind == 1) begin
                    c = ($urandom_range(0, 99) == 0);
                    if ($urandom_range(0, 19) == 0) pk = ~pk;
                end else begin
                    a = ($urandom_range(0, 199) == 0);
                    if ($urandom_range(0, 39) == 0) pk = ~pk;
                end
                cyc(r, t, a, b, c);
            end
        end
        idle(2);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
